// File: rtl/alu_operand_bank.sv
// alu_operand_bank: 32x32 register bank with two registered read ports,
// one write port and a 3-bit flag register. Option: ALU_OPERAND_BANK_BYPASS_EN.
module alu_operand_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic              sign_in,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              sign_flag
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Storage: entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read data selection: r0 masked to zero, optional write-to-read bypass.
    always_comb begin
        rs_next = '0;
        rt_next = '0;
        if (rs_addr != '0) begin
            rs_next = regs[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_next = regs[rt_addr];
        end
`ifdef ALU_OPERAND_BANK_BYPASS_EN
        if (wr_live && (wr_addr == rs_addr)) begin
            rs_next = wr_data;
        end
        if (wr_live && (wr_addr == rt_addr)) begin
            rt_next = wr_data;
        end
`endif
    end

    // Read output registers: capture on rd_en, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_data <= '0;
            rt_data <= '0;
        end else if (rd_en) begin
            rs_data <= rs_next;
            rt_data <= rt_next;
        end
    end

    // Flag register: loads the ALU flags on flag_we, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            sign_flag  <= 1'b0;
        end else if (flag_we) begin
            carry_flag <= carry_in;
            zero_flag  <= zero_in;
            sign_flag  <= sign_in;
        end
    end

endmodule

// File: tb/tb_alu_operand_bank.sv
// tb_alu_operand_bank: scoreboard bench for alu_operand_bank.
// Expected outputs are queued per edge and checked by a separate monitor.
module tb_alu_operand_bank;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [2:0]  f;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rd_en;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flag_we;
    logic        carry_in;
    logic        zero_in;
    logic        sign_in;
    logic        carry_flag;
    logic        zero_flag;
    logic        sign_flag;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] mem [32];
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    logic [2:0]  m_f;

    alu_operand_bank #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_en      (rd_en),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flag_we    (flag_we),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .sign_in    (sign_in),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .sign_flag  (sign_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a,
                                               input logic we,
                                               input logic [4:0] wa,
                                               input logic [31:0] wd);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = mem[a];
`ifdef ALU_OPERAND_BANK_BYPASS_EN
        if (we && wa == a) v = wd;
`endif
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        m_rs = 32'd0;
        m_rt = 32'd0;
        m_f  = 3'd0;
    endtask

    // Drive one edge's inputs and queue the outputs expected after it.
    task automatic step(input logic re, input logic [4:0] ra,
                        input logic [4:0] rb, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic fwe, input logic [2:0] fl);
        exp_t e;
        @(negedge clk);
        rd_en    = re;
        rs_addr  = ra;
        rt_addr  = rb;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        flag_we  = fwe;
        carry_in = fl[2];
        zero_in  = fl[1];
        sign_in  = fl[0];
        if (re) begin
            m_rs = model_read(ra, we, wa, wd);
            m_rt = model_read(rb, we, wa, wd);
        end
        if (we && wa != 5'd0) mem[wa] = wd;
        if (fwe) m_f = fl;
        e.rs = m_rs;
        e.rt = m_rt;
        e.f  = m_f;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        flag_we = 1'b0;
    endtask

    // Monitor: one queued expectation per edge, sampled just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rs_data", rs_data, e.rs);
            check("rt_data", rt_data, e.rt);
            check("flags", {29'd0, carry_flag, zero_flag, sign_flag},
                  {29'd0, e.f});
        end
    end

    initial begin
        rst = 1'b0;
        rs_addr = '0;
        rt_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        carry_in = 1'b0;
        zero_in = 1'b0;
        sign_in = 1'b0;
        idle();
        model_clear();
        repeat (2) @(negedge clk);
        check("reset_rs", rs_data, 32'd0);
        check("reset_rt", rt_data, 32'd0);
        check("reset_flags", {29'd0, carry_flag, zero_flag, sign_flag}, 32'd0);
        rst = 1'b1;

        // Preload r5 and flags, then reset mid-cycle.
        step(0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 3'b111);
        step(1, 5, 5, 0, 0, 0, 0, 3'b000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_rs", rs_data, 32'd0);
        check("async_rst_rt", rt_data, 32'd0);
        check("async_rst_flags", {29'd0, carry_flag, zero_flag, sign_flag},
              32'd0);
        model_clear();
        wr_en = 1'b1;
        wr_addr = 5'd6;
        wr_data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        idle();
        rst = 1'b1;
        step(1, 5, 6, 0, 0, 0, 0, 3'b000);

        // Write/read pair.
        step(0, 0, 0, 1, 3, 32'd15, 0, 3'b000);
        step(0, 0, 0, 1, 7, 32'd10, 0, 3'b000);
        step(1, 3, 7, 0, 0, 0, 0, 3'b000);

        // r0 protection.
        step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 3'b000);
        step(1, 0, 0, 0, 0, 0, 0, 3'b000);

        // Collision, then follow-up read.
        step(0, 0, 0, 1, 4, 32'd1, 0, 3'b000);
        step(1, 4, 4, 1, 4, 32'd99, 0, 3'b000);
        step(1, 4, 0, 0, 0, 0, 0, 3'b000);

        // Flags load then hold.
        step(0, 0, 0, 0, 0, 0, 1, 3'b101);
        step(0, 0, 0, 0, 0, 0, 0, 3'b010);

        // Hold while the read register changes.
        step(0, 0, 0, 1, 2, 32'd5, 0, 3'b000);
        step(1, 2, 2, 0, 0, 0, 0, 3'b000);
        step(0, 2, 2, 1, 2, 32'd6, 0, 3'b000);
        step(0, 2, 2, 0, 0, 0, 0, 3'b000);
        step(1, 2, 2, 0, 0, 0, 0, 3'b000);

        // Random traffic on a narrow address range to force collisions.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(3, 0) != 0,
                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                 $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)),
                 $urandom, $urandom_range(1, 0) == 1,
                 3'($urandom_range(7, 0)));
        end
        @(negedge clk);
        idle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
